bus_grant_ctrl: RTL
===================

# bus_grant_ctrl

Downstream consumer of the two-requester arbiter's grant outputs. Takes one-hot grants `gnt0`/`gnt1`, muxes the granted requester's valid/data stream onto a single registered shared bus, and gives back per-requester backpressure. Counts accepted beats per requester, flags illegal grant patterns, and can optionally cap a grant tenure with a burst limit that asks the owner to release.

## Interface
- `DATA_W`, 8: width of requester and bus data.
- `MAX_BEATS`, 4: beats allowed per tenure when the burst limit is compiled in; legal range 1..255.
- `CNT_W`, 8: width of the per-requester beat counters.

Ports:
- `clock`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-low reset (0 = reset).
- `gnt0`  in  1  grant to requester 0, from the arbiter.
- `gnt1`  in  1  grant to requester 1, from the arbiter.
- `valid0` / `valid1`  in  1  requester n presents a beat.
- `data0` / `data1`  in  DATA_W  requester n beat data.
- `ready0` / `ready1`  out  1  requester n beat accepted this cycle when `valid_n` && `ready_n`.
- `bus_valid`  out  1  shared bus holds a beat.
- `bus_data`  out  DATA_W  shared bus data.
- `bus_owner`  out  2  0 = none, 1 = requester 0, 2 = requester 1.
- `bus_ready`  in  1  sink accepts the bus beat when `bus_valid` && `bus_ready`.
- `release0` / `release1`  out  1  burst limit reached; requester n must drop its request.
- `beats0` / `beats1`  out  CNT_W  total beats accepted from requester n.
- `err`  out  1  sticky illegal-grant flag.

## Operation
- States: IDLE, OWN0, OWN1, DRAIN. `bus_owner` reads 0 in IDLE, 1 in OWN0, 2 in OWN1, and holds the last owner in DRAIN.
- **IDLE**
  - `gnt0` && !`gnt1` → OWN0.
  - `gnt1` && !`gnt0` → OWN1.
  - Both high → set `err`, stay in IDLE.
  - Neither high → stay.
- **OWNn**
  - `ready_n` = !`bus_valid` || `bus_ready` (with the burst limit, also AND `tenure_cnt` < MAX_BEATS). The other requester's ready is 0.
  - On acceptance: the output register loads `data_n`, `bus_valid` = 1, `beats_n` += 1 (wraps at 2^CNT_W), `tenure_cnt` += 1.
  - A bus handshake with no new acceptance clears `bus_valid`.
- **Exit from OWNn**
  - When `gnt_n` drops: if `bus_valid` && !`bus_ready` → DRAIN, else → IDLE. `tenure_cnt` clears on exit.
  - The other grant rising while in OWNn sets `err`; ownership is unchanged.
  - Both grants dropping and the other rising in the same cycle is handled as a drop; the new grant is taken from IDLE on a later cycle.
- **DRAIN**
  - Both readies are 0. On `bus_ready` the beat completes, `bus_valid` → 0, next state IDLE.
- `err` clears only on reset.

## Timing
- Reset values: state IDLE, `bus_valid` 0, `bus_data` 0, `bus_owner` 0, `ready0`/`ready1` 0, `release0`/`release1` 0, `beats0`/`beats1` 0, `err` 0.
- Reset mid-transfer discards any held beat; no completion is signalled.
- A grant seen at edge k puts `bus_owner` to the new value after edge k. The first `ready_n` = 1 is in the cycle after edge k.
- Beat latency: accepted at edge k → `bus_valid`/`bus_data` valid after edge k. Full throughput is 1 beat/cycle while `bus_ready` = 1.
- `ready_n` is combinational from state and the output register. No combinational path from `valid_n` to `ready_n`.
- `release_n` is registered and goes high the cycle after the MAX_BEATS-th acceptance. It holds until `gnt_n` drops.

## Configuration
- `BUS_GRANT_BURST_LIMIT_EN` defined:
  - `tenure_cnt` is instantiated.
  - After MAX_BEATS accepted beats, `ready_n` is forced to 0 and `release_n` asserts until the grant drops.
- Not defined:
  - No `tenure_cnt`; tenure is unlimited.
  - `release0`/`release1` are tied to 0.

## Test plan
- Reset: hold `reset` = 0 for 2 cycles with all inputs high → every output at its reset value, `err` 0.
- Basic burst: `gnt0` = 1, `bus_ready` = 1, beats 0xA1, 0xA2, 0xA3 on consecutive cycles → `bus_data` shows 0xA1..0xA3 one cycle later each, `bus_owner` = 1, `beats0` = 3. Drop `gnt0` → IDLE, `bus_owner` = 0.
- Backpressure/drain: in OWN1, `bus_ready` = 0 with 0x5C held → `ready1` = 0 and data stable. Drop `gnt1` → DRAIN, `bus_owner` stays 2. `bus_ready` = 1 → `bus_valid` 0, then IDLE.
- Burst limit (macro on, MAX_BEATS = 4): `gnt0` held, 6 beats offered → 4 accepted, `release0` = 1 from the cycle after the 4th acceptance, `beats0` = 4. With the macro off, all 6 are accepted and `release0` stays 0.
- Illegal grants: `gnt0` = `gnt1` = 1 in IDLE → `err` = 1, state stays IDLE, both readies 0. `err` persists until `reset` = 0.
- Counter wrap (CNT_W = 4): 17 beats from requester 1 → `beats1` = 1, `beats0` = 0.

Source files
------------

// File: rtl/bus_grant_ctrl.sv
// bus_grant_ctrl: takes one-hot grants from the two-requester arbiter, muxes
// the granted requester's valid/data stream onto a registered shared bus, and
// returns per-requester ready. Counts accepted beats per requester and keeps a
// sticky flag for illegal grant patterns.
//
// Optional feature macro: BUS_GRANT_BURST_LIMIT_EN
//   defined   -> each tenure is capped at MAX_BEATS beats; once reached, the
//                owner's ready is forced low and release_n is raised until
//                its grant drops.
//   undefined -> tenure is unlimited and release0/release1 are tied low.
module bus_grant_ctrl #(
    parameter int DATA_W    = 8,
    parameter int MAX_BEATS = 4,
    parameter int CNT_W     = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              gnt0,
    input  logic              gnt1,
    input  logic              valid0,
    input  logic              valid1,
    input  logic [DATA_W-1:0] data0,
    input  logic [DATA_W-1:0] data1,
    output logic              ready0,
    output logic              ready1,
    output logic              bus_valid,
    output logic [DATA_W-1:0] bus_data,
    output logic [1:0]        bus_owner,
    input  logic              bus_ready,
    output logic              release0,
    output logic              release1,
    output logic [CNT_W-1:0]  beats0,
    output logic [CNT_W-1:0]  beats1,
    output logic              err
);

    if (MAX_BEATS < 1 || MAX_BEATS > 255) begin : g_bad_max_beats
        $error("bus_grant_ctrl: MAX_BEATS must be in 1..255");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN0  = 2'd1,
        OWN1  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         owner_q, owner_d;
    logic               bus_valid_q, bus_valid_d;
    logic [DATA_W-1:0]  bus_data_q, bus_data_d;
    logic [CNT_W-1:0]   beats0_q, beats0_d;
    logic [CNT_W-1:0]   beats1_q, beats1_d;
    logic               err_q, err_d;
    logic               slot_free;
    logic               limit_ok;

`ifdef BUS_GRANT_BURST_LIMIT_EN
    localparam logic [7:0] MAX_BEATS_C = 8'(MAX_BEATS);

    logic [7:0] tenure_q, tenure_d;
    logic       rel0_q, rel0_d;
    logic       rel1_q, rel1_d;

    assign limit_ok = (tenure_q < MAX_BEATS_C);
    assign release0 = rel0_q;
    assign release1 = rel1_q;
`else
    assign limit_ok = 1'b1;
    assign release0 = 1'b0;
    assign release1 = 1'b0;
`endif

    // The output register can take a new beat when empty or when its beat
    // leaves this cycle; this never looks at valid_n.
    assign slot_free = !bus_valid_q || bus_ready;

    // Next-state, bus load, counters and per-requester ready.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        bus_valid_d = bus_valid_q;
        bus_data_d  = bus_data_q;
        beats0_d    = beats0_q;
        beats1_d    = beats1_q;
        err_d       = err_q;
        ready0      = 1'b0;
        ready1      = 1'b0;
`ifdef BUS_GRANT_BURST_LIMIT_EN
        tenure_d    = tenure_q;
        rel0_d      = 1'b0;
        rel1_d      = 1'b0;
`endif

        // A completed bus handshake empties the register unless reloaded below.
        if (bus_valid_q && bus_ready) begin
            bus_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (gnt0 && gnt1) begin
                    err_d = 1'b1;
                end else if (gnt0) begin
                    state_d = OWN0;
                    owner_d = 2'd1;
                end else if (gnt1) begin
                    state_d = OWN1;
                    owner_d = 2'd2;
                end
            end

            OWN0: begin
                ready0 = slot_free && limit_ok;
                if (valid0 && ready0) begin
                    bus_data_d  = data0;
                    bus_valid_d = 1'b1;
                    beats0_d    = beats0_q + CNT_W'(1);
`ifdef BUS_GRANT_BURST_LIMIT_EN
                    tenure_d    = tenure_q + 8'd1;
`endif
                end
                // A beat still held after this edge must drain before IDLE.
                if (!gnt0) begin
                    state_d = bus_valid_d ? DRAIN : IDLE;
                    owner_d = bus_valid_d ? 2'd1 : 2'd0;
`ifdef BUS_GRANT_BURST_LIMIT_EN
                    tenure_d = 8'd0;
`endif
                end else begin
                    if (gnt1) begin
                        err_d = 1'b1;
                    end
`ifdef BUS_GRANT_BURST_LIMIT_EN
                    rel0_d = (tenure_d >= MAX_BEATS_C);
`endif
                end
            end

            OWN1: begin
                ready1 = slot_free && limit_ok;
                if (valid1 && ready1) begin
                    bus_data_d  = data1;
                    bus_valid_d = 1'b1;
                    beats1_d    = beats1_q + CNT_W'(1);
`ifdef BUS_GRANT_BURST_LIMIT_EN
                    tenure_d    = tenure_q + 8'd1;
`endif
                end
                if (!gnt1) begin
                    state_d = bus_valid_d ? DRAIN : IDLE;
                    owner_d = bus_valid_d ? 2'd2 : 2'd0;
`ifdef BUS_GRANT_BURST_LIMIT_EN
                    tenure_d = 8'd0;
`endif
                end else begin
                    if (gnt0) begin
                        err_d = 1'b1;
                    end
`ifdef BUS_GRANT_BURST_LIMIT_EN
                    rel1_d = (tenure_d >= MAX_BEATS_C);
`endif
                end
            end

            DRAIN: begin
                if (bus_ready) begin
                    state_d = IDLE;
                    owner_d = 2'd0;
                end
            end

            default: begin
                state_d = IDLE;
                owner_d = 2'd0;
            end
        endcase
    end

    // State and output registers; reset discards any held beat.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= IDLE;
            owner_q     <= 2'd0;
            bus_valid_q <= 1'b0;
            bus_data_q  <= '0;
            beats0_q    <= '0;
            beats1_q    <= '0;
            err_q       <= 1'b0;
`ifdef BUS_GRANT_BURST_LIMIT_EN
            tenure_q    <= 8'd0;
            rel0_q      <= 1'b0;
            rel1_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            bus_valid_q <= bus_valid_d;
            bus_data_q  <= bus_data_d;
            beats0_q    <= beats0_d;
            beats1_q    <= beats1_d;
            err_q       <= err_d;
`ifdef BUS_GRANT_BURST_LIMIT_EN
            tenure_q    <= tenure_d;
            rel0_q      <= rel0_d;
            rel1_q      <= rel1_d;
`endif
        end
    end

    assign bus_valid = bus_valid_q;
    assign bus_data  = bus_data_q;
    assign bus_owner = owner_q;
    assign beats0    = beats0_q;
    assign beats1    = beats1_q;
    assign err       = err_q;

endmodule
